// File: rtl/tweet_pkg.sv
// ============================================================================
// Module      : tweet_pkg
// Description : Shared constants and the playback state encoding used by the
//               tweetboard message player. State PARITY exists only when
//               TWEET_PLAYER_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tweet_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 5208;
  localparam int MAX_CHARS_DEFAULT    = 160;
  localparam int VALID_BIT            = 15;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_CHECK  = 4'd2,
    ST_START  = 4'd3,
    ST_DATA   = 4'd4,
`ifdef TWEET_PLAYER_PARITY_EN
    ST_PARITY = 4'd8,
`endif
    ST_STOP   = 4'd5,
    ST_NEXT   = 4'd6,
    ST_DONE   = 4'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module      : uart_bit_timer
// Description : Baud counter. Runs 0..CLKS_PER_BIT-1, asserts tick on the
//               last count and wraps to 0. A synchronous clear restarts it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bit_timer
  import tweet_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // Free-running bit-period counter, restarted by reset or clear
  always_ff @(posedge sysclk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tweet_player.sv
// ============================================================================
// Module      : tweet_player
// Description : Reads characters from the message RAM starting at address 0
//               and serialises them on a UART line (8N1). Playback ends at
//               the first invalid word, at MAX_CHARS, or after an abort.
//               Define TWEET_PLAYER_PARITY_EN to add an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tweet_player
  import tweet_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int MAX_CHARS    = MAX_CHARS_DEFAULT,
  parameter int ADDR_W       = 8,
  parameter int WORD_W       = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              go,
  input  logic              abort,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] char_count
);

  state_t          state;
  state_t          state_next;
  logic            tick;
  logic            timer_clear;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic            abort_latch;
  logic [ADDR_W:0] count_inc;
  logic            last_char;
  logic            word_valid;
  logic            unused_rdata;
`ifdef TWEET_PLAYER_PARITY_EN
  logic            parity_bit;
`endif

  // Middle RAM bits carry nothing this engine needs
  assign unused_rdata = ^ram_rdata[WORD_W-2:8];

  assign word_valid  = ram_rdata[WORD_W-1];
  assign count_inc   = {1'b0, char_count} + 1'b1;
  assign last_char   = (count_inc == (ADDR_W+1)'(MAX_CHARS));
  // Every state change restarts the bit period from zero
  assign timer_clear = (state_next != state);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (timer_clear),
    .tick   (tick)
  );

  // State register
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (go) state_next = ST_FETCH;
      ST_FETCH: state_next = ST_CHECK;
      ST_CHECK: state_next = (!word_valid || abort_latch) ? ST_DONE : ST_START;
      ST_START: if (tick) state_next = ST_DATA;
`ifdef TWEET_PLAYER_PARITY_EN
      ST_DATA:   if (tick && bit_idx == 3'd7) state_next = ST_PARITY;
      ST_PARITY: if (tick) state_next = ST_STOP;
`else
      ST_DATA:   if (tick && bit_idx == 3'd7) state_next = ST_STOP;
`endif
      ST_STOP:  if (tick) state_next = ST_NEXT;
      ST_NEXT:  state_next = last_char ? ST_DONE : ST_FETCH;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Address, count, abort latch and character shift register
  always_ff @(posedge sysclk) begin
    if (reset) begin
      ram_addr    <= '0;
      char_count  <= '0;
      abort_latch <= 1'b0;
      shreg       <= '0;
      bit_idx     <= '0;
`ifdef TWEET_PLAYER_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      if (state != ST_IDLE && abort) begin
        abort_latch <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (go) begin
            ram_addr    <= '0;
            char_count  <= '0;
            abort_latch <= 1'b0;
          end
        end
        ST_CHECK: begin
          shreg      <= ram_rdata[7:0];
          bit_idx    <= '0;
`ifdef TWEET_PLAYER_PARITY_EN
          parity_bit <= ^ram_rdata[7:0];
`endif
        end
        ST_DATA: begin
          if (tick) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        ST_NEXT: begin
          char_count <= count_inc[ADDR_W-1:0];
          if (!last_char) begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line level decoded from the registered state; idle/gap/stop are high
  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shreg[0];
`ifdef TWEET_PLAYER_PARITY_EN
      ST_PARITY: tx = parity_bit;
`endif
      default:   tx = 1'b1;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_tweet_player.sv
// ============================================================================
// Module      : tb_tweet_player
// Description : Scoreboard bench for tweet_player (CLKS_PER_BIT=4). Expected
//               characters and end-of-playback counts are queued with each
//               stimulus; monitors decode tx frames and done pulses and
//               compare against the queues.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tweet_player;

  localparam int CPB  = 4;
  localparam int MAXC = 160;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        go     = 1'b0;
  logic        abort  = 1'b0;
  logic [7:0]  ram_addr;
  logic [15:0] ram_rdata;
  logic        tx;
  logic        busy;
  logic        done;
  logic [7:0]  char_count;

  logic [15:0] mem [256];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  byte unsigned exp_bytes[$];
  int          exp_counts[$];
  int          start_q[$];
  bit          mon_go = 1'b0;
  bit          ignore_frames = 1'b0;
  int          addr_hi_cnt = 0;
  int          tx_low_cnt = 0;

  tweet_player #(
    .CLKS_PER_BIT (CPB),
    .MAX_CHARS    (MAXC),
    .ADDR_W       (8),
    .WORD_W       (16)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .go         (go),
    .abort      (abort),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .char_count (char_count)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Registered-read message RAM
  always @(posedge sysclk) ram_rdata <= mem[ram_addr];

  always @(negedge sysclk) begin
    if (mon_go && busy === 1'b1 && ram_addr >= 8'(MAXC)) addr_hi_cnt <= addr_hi_cnt + 1;
    if (mon_go && tx !== 1'b1) tx_low_cnt <= tx_low_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle line samples for one complete frame of byte b
  function automatic logic [10*CPB-1:0] frame_pattern(input logic [7:0] b);
    logic [10*CPB-1:0] p;
    logic              bv;
    p = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      bv = 1'b0;
      else if (k == 9) bv = 1'b1;
      else             bv = b[k-1];
      for (int j = 0; j < CPB; j++) p[k*CPB + j] = bv;
    end
    return p;
  endfunction

  // Frame monitor: capture 10 bit times from the first low sample
  initial begin : mon_tx
    logic [10*CPB-1:0] samp;
    int                st;
    byte unsigned      b;
    wait (mon_go);
    forever begin
      @(negedge sysclk);
      if (tx !== 1'b1) begin
        st      = cyc;
        samp    = '0;
        samp[0] = tx;
        for (int i = 1; i < 10*CPB; i++) begin
          @(negedge sysclk);
          samp[i] = tx;
        end
        start_q.push_back(st);
        if (!ignore_frames) begin
          if (exp_bytes.size() == 0) begin
            check("unexpected_frame", samp, '1);
          end else begin
            b = exp_bytes.pop_front();
            check("frame", samp, frame_pattern(b));
          end
        end
      end
    end
  end

  // Done monitor: compare final char_count on every done pulse
  initial begin : mon_done
    wait (mon_go);
    forever begin
      @(negedge sysclk);
      if (done === 1'b1) begin
        if (exp_counts.size() == 0) begin
          check("unexpected_done", char_count, 8'hFF);
        end else begin
          check("done_char_count", char_count, exp_counts.pop_front());
        end
      end
    end
  end

  task automatic pulse_go(output int edge_cyc);
    @(negedge sysclk);
    go = 1'b1;
    @(negedge sysclk);
    go = 1'b0;
    edge_cyc = cyc;
  endtask

  task automatic wait_done(input int max_cyc, output int dc);
    int n;
    n  = 0;
    dc = -1;
    while (n < max_cyc && dc < 0) begin
      @(negedge sysclk);
      if (done === 1'b1) dc = cyc;
      n++;
    end
    check("done_seen", (dc >= 0), 1'b1);
  endtask

  task automatic check_idle_after_done(input string tag);
    @(negedge sysclk);
    check({tag, "_done_low"}, done, 1'b0);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e;
    int dc;
    int snap;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // Reset state
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ram_addr", ram_addr, 8'h00);
    check("rst_char_count", char_count, 8'h00);
    reset = 1'b0;
    mon_go = 1'b1;

    // Single character 'A'
    mem[0] = 16'h8041; mem[1] = 16'h0000;
    start_q.delete();
    exp_bytes.push_back(8'h41);
    exp_counts.push_back(1);
    pulse_go(e);
    wait_done(200, dc);
    check("a_first_start", start_q.size() > 0 ? start_q[0] : -1, e + 2);
    check("a_done_cycle", dc, e + 45);
    check_idle_after_done("a");

    // Three characters, frame spacing 43 cycles
    mem[0] = 16'h8048; mem[1] = 16'h8069; mem[2] = 16'h8021; mem[3] = 16'h0000;
    start_q.delete();
    exp_bytes.push_back(8'h48); exp_bytes.push_back(8'h69); exp_bytes.push_back(8'h21);
    exp_counts.push_back(3);
    pulse_go(e);
    wait_done(400, dc);
    check("hi_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("hi_first_start", start_q[0], e + 2);
      check("hi_spacing_01", start_q[1] - start_q[0], 43);
      check("hi_spacing_12", start_q[2] - start_q[1], 43);
    end
    check("hi_done_cycle", dc, e + 131);
    check("hi_ram_addr", ram_addr, 8'd3);
    check_idle_after_done("hi");

    // Full RAM: stop at MAX_CHARS
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000 | 16'(i);
    start_q.delete();
    for (int i = 0; i < MAXC; i++) exp_bytes.push_back(8'(i));
    exp_counts.push_back(MAXC);
    snap = addr_hi_cnt;
    pulse_go(e);
    wait_done(MAXC * 43 + 100, dc);
    check("full_frames", start_q.size(), MAXC);
    check("full_ram_addr", ram_addr, 8'd159);
    check("full_char_count", char_count, 8'd160);
    check("full_addr_limit", addr_hi_cnt - snap, 0);
    check_idle_after_done("full");

    // Empty RAM
    mem[0] = 16'h0000;
    start_q.delete();
    exp_counts.push_back(0);
    snap = tx_low_cnt;
    pulse_go(e);
    wait_done(50, dc);
    check("empty_done_cycle", dc, e + 2);
    check("empty_tx_quiet", tx_low_cnt - snap, 0);
    check_idle_after_done("empty");

    // Abort during data bit 3 of the first character
    for (int i = 0; i < 5; i++) mem[i] = 16'h8031 + 16'(i);
    mem[5] = 16'h0000;
    start_q.delete();
    exp_bytes.push_back(8'h31);
    exp_counts.push_back(1);
    pulse_go(e);
    while (cyc < e + 18) @(negedge sysclk);
    abort = 1'b1;
    @(negedge sysclk);
    abort = 1'b0;
    wait_done(200, dc);
    check("abort_done_cycle", dc, e + 45);
    check("abort_frames", start_q.size(), 1);
    check("abort_ram_addr", ram_addr, 8'd1);
    check_idle_after_done("abort");

    // Reset in the middle of DATA, then replay from address 0
    mem[0] = 16'h8052; mem[1] = 16'h804B; mem[2] = 16'h0000;
    ignore_frames = 1'b1;
    pulse_go(e);
    while (cyc < e + 12) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_char_count", char_count, 8'd0);
    reset = 1'b0;
    repeat (45) @(negedge sysclk);
    ignore_frames = 1'b0;
    start_q.delete();
    exp_bytes.push_back(8'h52); exp_bytes.push_back(8'h4B);
    exp_counts.push_back(2);
    pulse_go(e);
    wait_done(300, dc);
    check("replay_first_start", start_q.size() > 0 ? start_q[0] : -1, e + 2);
    check("replay_done_cycle", dc, e + 88);
    check_idle_after_done("replay");

    repeat (5) @(negedge sysclk);
    check("left_bytes", exp_bytes.size(), 0);
    check("left_counts", exp_counts.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
